// File: rtl/imem_loader.sv
// Byte-stream program loader: frames SYNC, N, then N big-endian 16-bit words into instruction memory.
// Define IMEM_LOADER_CKSUM_EN to require a trailing 8-bit checksum byte (sum of N and all data bytes).
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_wen,
  output logic [7:0]  imem_waddr,
  output logic [15:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_cnt
);

  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CKSUM, WAIT, DONE} state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] hi;
  logic       accept;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] acc;
`endif

  // Only WAIT and DONE refuse bytes; there is no other back-pressure.
  assign in_ready = (state != WAIT) && (state != DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= 8'h00;
      hi         <= 8'h00;
      imem_wen   <= 1'b0;
      imem_waddr <= 8'h00;
      imem_wdata <= 16'h0000;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= 8'h00;
`ifdef IMEM_LOADER_CKSUM_EN
      acc        <= 8'h00;
`endif
    end else begin
      imem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state    <= LEN;
            err      <= 1'b0;
            word_cnt <= 8'h00;
`ifdef IMEM_LOADER_CKSUM_EN
            acc      <= 8'h00;
`endif
          end
        end
        LEN: begin
          if (accept) begin
            len <= in_data;
`ifdef IMEM_LOADER_CKSUM_EN
            acc <= in_data;
`endif
            if (in_data == 8'h00) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            hi    <= in_data;
`ifdef IMEM_LOADER_CKSUM_EN
            acc   <= acc + in_data;
`endif
            state <= LO;
          end
        end
        LO: begin
          if (accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
            acc        <= acc + in_data;
`endif
            imem_wen   <= 1'b1;
            imem_waddr <= BASE_ADDR + word_cnt;
            imem_wdata <= {hi, in_data};
            word_cnt   <= word_cnt + 8'd1;
            if (word_cnt + 8'd1 == len) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state <= CKSUM;
`else
              state <= WAIT;
`endif
            end else begin
              state <= HI;
            end
          end
        end
        CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
          if (accept) begin
            if (in_data == acc) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
`else
          state <= IDLE;
`endif
        end
        WAIT: begin
          // The final write issued on the previous edge lands before the CPU is released.
          state   <= DONE;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for the main frame plus hand sequences for corner cases.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy0, wen0, crst0, dn0, er0;
  logic [7:0]  addr0, wc0;
  logic [15:0] data0;
  logic        rdy1, wen1, crst1, dn1, er1;
  logic [7:0]  addr1, wc1;
  logic [15:0] data1;

  int compared = 0;
  int mismatched = 0;
  int wen_double = 0;
  logic wen_prev0 = 1'b0;
  logic wen_prev1 = 1'b0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .imem_wen(wen0), .imem_waddr(addr0), .imem_wdata(data0), .cpu_rst(crst0),
    .done(dn0), .err(er0), .word_cnt(wc0)
  );

  imem_loader #(.BASE_ADDR(8'hFF), .SYNC_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .imem_wen(wen1), .imem_waddr(addr1), .imem_wdata(data1), .cpu_rst(crst1),
    .done(dn1), .err(er1), .word_cnt(wc1)
  );

  // Record every write and catch any enable held for two cycles.
  always @(negedge clk) begin
    if (wen0) q0.push_back({addr0, data0});
    if (wen1) q1.push_back({addr1, data1});
    if (wen0 && wen_prev0) wen_double++;
    if (wen1 && wen_prev1) wen_double++;
    wen_prev0 = wen0;
    wen_prev1 = wen1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!rdy0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy0) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: byte %0h not accepted in 50 cycles", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_good(input int gap);
    send(8'hA5, gap); send(8'h02, gap); send(8'h51, gap);
    send(8'h23, gap); send(8'hF0, gap); send(8'h00, gap);
`ifdef IMEM_LOADER_CKSUM_EN
    send(8'h66, gap);
`endif
  endtask

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        wen;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        crst;
    logic        dn;
    logic        er;
    logic [7:0]  wc;
    logic        rdy;
  } vec_t;

  vec_t vt[16];

`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic       LAST_RDY  = 1'b1;
  localparam logic [7:0] LAST_BYTE = 8'h66;
`else
  localparam logic       LAST_RDY  = 1'b0;
  localparam logic [7:0] LAST_BYTE = 8'hAA;
`endif

  initial begin
    int n0;
    //          rst v  d      wen addr   data      crst dn er wc    rdy
    vt[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 8'h51, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 8'h51, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
    vt[11] = '{1'b0, 1'b1, 8'h23, 1'b1, 8'h00, 16'h5123, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
    vt[12] = '{1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 16'h5123, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
    vt[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 16'hF000, 1'b1, 1'b0, 1'b0, 8'd2, LAST_RDY};
    vt[14] = '{1'b0, 1'b1, LAST_BYTE, 1'b0, 8'h01, 16'hF000, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vt[15] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h01, 16'hF000, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};

    for (int i = 0; i < 16; i++) begin
      rst = vt[i].rst;
      in_valid = vt[i].v;
      in_data = vt[i].d;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wen", i), {31'd0, wen0}, {31'd0, vt[i].wen});
      check($sformatf("v%0d_waddr", i), {24'd0, addr0}, {24'd0, vt[i].addr});
      check($sformatf("v%0d_wdata", i), {16'd0, data0}, {16'd0, vt[i].data});
      check($sformatf("v%0d_cpu_rst", i), {31'd0, crst0}, {31'd0, vt[i].crst});
      check($sformatf("v%0d_done", i), {31'd0, dn0}, {31'd0, vt[i].dn});
      check($sformatf("v%0d_err", i), {31'd0, er0}, {31'd0, vt[i].er});
      check($sformatf("v%0d_word_cnt", i), {24'd0, wc0}, {24'd0, vt[i].wc});
      check($sformatf("v%0d_in_ready", i), {31'd0, rdy0}, {31'd0, vt[i].rdy});
    end
    in_valid = 1'b0;
    #1;
    check("tbl_q0_size", q0.size(), 2);
    check("tbl_q1_size", q1.size(), 2);
    if (q0.size() == 2 && q1.size() == 2) begin
      check("tbl_q0_w0", {8'd0, q0[0]}, 32'h0000_5123);
      check("tbl_q0_w1", {8'd0, q0[1]}, 32'h0001_F000);
      check("tbl_q1_w0", {8'd0, q1[0]}, 32'h00FF_5123);
      check("tbl_q1_w1", {8'd0, q1[1]}, 32'h0000_F000);
    end

    // Mid-frame reset: one word written, then the frame is abandoned.
    do_reset();
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
    check("mid_wc_before", {24'd0, wc0}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = q0.size();
    check("mid_wc_after", {24'd0, wc0}, 32'd0);
    check("mid_cpu_rst", {31'd0, crst0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_writes", q0.size(), n0);
    q0.delete();
    q1.delete();

    // Good frame with in_valid toggling every other cycle; BASE_ADDR=FF instance wraps.
    send_good(1);
    check("stall_done", {31'd0, dn0}, 32'd1);
    check("stall_cpu_rst", {31'd0, crst0}, 32'd0);
    check("stall_q0_size", q0.size(), 2);
    check("stall_q1_size", q1.size(), 2);
    if (q0.size() == 2 && q1.size() == 2) begin
      check("stall_q0_w0", {8'd0, q0[0]}, 32'h0000_5123);
      check("stall_q0_w1", {8'd0, q0[1]}, 32'h0001_F000);
      check("wrap_q1_w0", {8'd0, q1[0]}, 32'h00FF_5123);
      check("wrap_q1_w1", {8'd0, q1[1]}, 32'h0000_F000);
    end
    check("wrap_done", {31'd0, dn1}, 32'd1);

`ifdef IMEM_LOADER_CKSUM_EN
    // Bad checksum, then recovery with the good frame.
    do_reset();
    send(8'hA5, 0); send(8'h02, 0); send(8'h51, 0);
    send(8'h23, 0); send(8'hF0, 0); send(8'h00, 0); send(8'h67, 0);
    check("bad_err", {31'd0, er0}, 32'd1);
    check("bad_done", {31'd0, dn0}, 32'd0);
    check("bad_cpu_rst", {31'd0, crst0}, 32'd1);
    send(8'hA5, 0);
    check("recover_err_clr", {31'd0, er0}, 32'd0);
    send(8'h02, 0); send(8'h51, 0); send(8'h23, 0);
    send(8'hF0, 0); send(8'h00, 0); send(8'h66, 0);
    check("recover_done", {31'd0, dn0}, 32'd1);
    check("recover_cpu_rst", {31'd0, crst0}, 32'd0);
    check("recover_ready", {31'd0, rdy0}, 32'd0);
`else
    // Single-word frame without checksum: WAIT then DONE.
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'hF0, 0);
    send(8'h00, 0);
    check("nock_wen", {31'd0, wen0}, 32'd1);
    check("nock_done_early", {31'd0, dn0}, 32'd0);
    check("nock_ready_wait", {31'd0, rdy0}, 32'd0);
    @(posedge clk);
    #1;
    check("nock_done", {31'd0, dn0}, 32'd1);
    check("nock_cpu_rst", {31'd0, crst0}, 32'd0);
    check("nock_wen_off", {31'd0, wen0}, 32'd0);
    check("nock_ready_done", {31'd0, rdy0}, 32'd0);
    check("nock_q0_size", q0.size(), 1);
    if (q0.size() == 1) check("nock_q0_w0", {8'd0, q0[0]}, 32'h0000_F000);
    check("nock_q1_w0", (q1.size() == 1) ? {8'd0, q1[0]} : 32'hFFFF_FFFF, 32'h00FF_F000);
`endif

    check("wen_single_cycle", wen_double, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the CPU's instruction memory.
- Receives a framed byte stream over a valid/ready interface.
- Assembles 16-bit instruction words, most significant byte first, and writes them into the writable instruction memory port.
- Holds the CPU in reset until a complete, valid image has been written, then releases it.

Parameters:
- BASE_ADDR, 8'h00, instruction-memory address of the first loaded word.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a byte is present on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a byte transfers on an edge where in_valid && in_ready.
- imem_wen  output  1  instruction-memory write enable; one-cycle pulse per word.
- imem_waddr  output  8  write address.
- imem_wdata  output  16  write data, {hi_byte, lo_byte}.
- cpu_rst  output  1  reset to the CPU; high until load completes.
- done  output  1  image loaded and accepted; sticky until rst.
- err  output  1  framing or checksum error; sticky until the next SYNC_BYTE is accepted.
- word_cnt  output  8  number of words written in the current frame.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: imem_wen=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, word_cnt=0, state=IDLE.
- Reset does not clear instruction-memory contents.
- Reset mid-frame: the partial frame is abandoned and the next edge starts in IDLE.
- in_ready is combinational from state: 1 in IDLE, LEN, HI, LO and CKSUM; 0 in WAIT and DONE. It is not otherwise back-pressured.
- IDLE:
  - Accepted bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE -> go to LEN; clear err, word_cnt and the checksum accumulator.
- LEN:
  - Accepted byte N is latched; the accumulator is initialised to N.
  - N=0 -> set err, return to IDLE.
  - Otherwise go to HI.
- HI: latch the byte as hi; add it to the accumulator; go to LO.
- LO:
  - Add the byte to the accumulator.
  - On the edge accepting it: imem_wen=1, imem_waddr=BASE_ADDR+word_cnt (mod 256), imem_wdata={hi, byte}.
  - imem_wen is high for exactly the following cycle, then deasserts unless another write is issued.
  - word_cnt increments on the same edge.
  - If word_cnt+1==N, go to CKSUM (feature enabled) or WAIT (feature disabled); else go to HI.
- Address arithmetic is 8-bit and wraps (BASE_ADDR=8'hFF, second word -> 8'h00).
- Accumulator is an 8-bit sum modulo 256 of N and every data byte.
- CKSUM:
  - Accepted byte equals the accumulator -> go to DONE.
  - Otherwise set err, return to IDLE; cpu_rst stays 1.
- WAIT: one cycle, letting the final write land; then go to DONE.
- DONE (terminal until rst):
  - done=1 and cpu_rst=0, registered: they appear on the edge that enters DONE.
  - imem_wen=0.
  - in_valid is ignored.
- The last instruction-memory write always completes at or before the edge on which cpu_rst falls.
- Gaps in in_valid are allowed in any state; no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined: frame is SYNC, N, 2N data bytes, checksum byte; the CKSUM state is used and WAIT is not.
- Undefined: no checksum byte; after the last LO byte the FSM goes to WAIT, then DONE; the accumulator logic is removed; err is raised only for N=0.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1, in_data=8'hA5 -> imem_wen=0, cpu_rst=1, done=0, err=0, word_cnt=0 throughout.
- Good frame (CKSUM_EN, BASE_ADDR=0): stream A5 02 51 23 F0 00 66 -> writes (00, 16'h5123) then (01, 16'hF000), each a single-cycle imem_wen; word_cnt=2; done=1 and cpu_rst=0 on the edge after byte 66; in_ready=0 afterwards.
- Bad checksum: same frame ending 67 -> err=1, done=0, cpu_rst=1. Then resend the good frame -> err clears on A5 acceptance, done=1.
- Garbage, zero length, mid-frame reset: leading bytes 00 FF 12 are ignored. Frame A5 00 -> err=1, back in IDLE. Frame A5 03 11 22 with rst pulsed before the next byte -> word_cnt=0, no further writes; a following good frame loads correctly.
- Wrap and stalls: BASE_ADDR=8'hFF, N=2, in_valid toggled every other cycle -> waddr FF then 00; no byte lost or duplicated.
- Feature disabled: stream A5 01 F0 00 -> one write (BASE_ADDR, 16'hF000); done=1 two edges after the 00 byte is accepted; no checksum byte consumed.
